// File: rtl/digit_serial_adder_if.sv
// Handshake and operand/result bundle between a sequencer (master) and the
// digit-serial adder (slave).
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor that reuses one DIGIT-bit ripple slice,
// consuming the operands least-significant digit first.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    digit_serial_adder_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH % DIGIT != 0) begin : gBadParam
            $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT:0]       sliceSum;
    logic                 carry_d;
    logic                 msbCarryIn;
    logic [WIDTH+DIGIT-1:0] resWide;
    logic [WIDTH-1:0]     res_d;
    logic                 lastDigit;

    assign sliceSum   = {1'b0, opA_q[DIGIT-1:0]} + {1'b0, opB_q[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, carry_q};
    assign carry_d    = sliceSum[DIGIT];
    // Recover the carry into the top bit of this digit from its sum bit.
    assign msbCarryIn = opA_q[DIGIT-1] ^ opB_q[DIGIT-1] ^ sliceSum[DIGIT-1];
    assign resWide    = {sliceSum[DIGIT-1:0], res_q};
    assign res_d      = resWide[WIDTH+DIGIT-1:DIGIT];
    assign lastDigit  = (cnt_q == CW'(NDIG - 1));

    // Subtraction is a + ~b + ~cin, so the inversion happens once at load time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        opA_q   <= bus.a;
                        opB_q   <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.cin ^ bus.sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    opA_q   <= opA_q >> DIGIT;
                    opB_q   <= opB_q >> DIGIT;
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (lastDigit) begin
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        ovf_q   <= msbCarryIn ^ carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed checks on the default 16/4 adder plus random sweeps on three
// other WIDTH/DIGIT shapes against a signed/unsigned integer model.
module tb_digit_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checksDone = 0;
    int   checksPassed = 0;
    logic directedDone = 1'b0;
    logic [2:0] sweepDone = 3'b000;
    logic [15:0] prevSum = 16'h0000;

    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(16)) dutBus ();

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (dutBus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checksDone++;
        if (observed === expected) checksPassed++;
        else $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Drives one request for one edge, then scrambles the inputs while busy.
    task automatic applyStimulus(input logic s, input logic c,
                                 input logic [15:0] x, input logic [15:0] y);
        dutBus.start = 1'b1;
        dutBus.sub   = s;
        dutBus.cin   = c;
        dutBus.a     = x;
        dutBus.b     = y;
        @(posedge clk);
        #1;
        dutBus.start = 1'b0;
        dutBus.sub   = ~s;
        dutBus.cin   = ~c;
        dutBus.a     = ~x;
        dutBus.b     = x ^ y;
    endtask

    task automatic runVector(input string tag, input logic s, input logic c,
                             input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] eSum, input logic eCout,
                             input logic eOvf, input logic interfere);
        int lat;
        int busyCnt;
        applyStimulus(s, c, x, y);
        checkOutput({tag, " hold"}, 64'(dutBus.sum), 64'(prevSum));
        busyCnt = dutBus.busy ? 1 : 0;
        lat = 0;
        while (lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
            if (interfere && lat == 1) begin
                dutBus.start = 1'b1;
                dutBus.sub   = 1'b1;
                dutBus.a     = 16'hFFFF;
                dutBus.b     = 16'hFFFF;
            end
            if (interfere && lat == 2) dutBus.start = 1'b0;
            if (dutBus.done) break;
            if (dutBus.busy) busyCnt++;
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'd4);
        checkOutput({tag, " busyCycles"}, 64'(busyCnt), 64'd4);
        checkOutput({tag, " busyAtDone"}, 64'(dutBus.busy), 64'd0);
        checkOutput({tag, " sum"}, 64'(dutBus.sum), 64'(eSum));
        checkOutput({tag, " cout"}, 64'(dutBus.cout), 64'(eCout));
        checkOutput({tag, " ovf"}, 64'(dutBus.ovf), 64'(eOvf));
        prevSum = eSum;
    endtask

    initial begin
        logic doneSeen;
        dutBus.start = 1'b0;
        dutBus.sub   = 1'b0;
        dutBus.cin   = 1'b0;
        dutBus.a     = '0;
        dutBus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(dutBus.busy), 64'd0);
        checkOutput("reset done", 64'(dutBus.done), 64'd0);
        checkOutput("reset sum", 64'(dutBus.sum), 64'd0);
        checkOutput("reset cout", 64'(dutBus.cout), 64'd0);
        checkOutput("reset ovf", 64'(dutBus.ovf), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Each vector starts in the cycle the previous one reports done.
        runVector("add1234", 1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0);
        runVector("addWrap", 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
        runVector("addOvf", 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        runVector("addCin", 1'b0, 1'b1, 16'h00FF, 16'h0F00, 16'h1000, 1'b0, 1'b0, 1'b0);
        runVector("sub5m3", 1'b1, 1'b0, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0);
        runVector("sub3m5", 1'b1, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        runVector("subOvf", 1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        runVector("subCin", 1'b1, 1'b1, 16'h0010, 16'h0010, 16'hFFFF, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        checkOutput("donePulseWidth", 64'(dutBus.done), 64'd0);
        checkOutput("idleAfterDone", 64'(dutBus.busy), 64'd0);

        runVector("startWhileBusy", 1'b0, 1'b0, 16'h8111, 16'h8222, 16'h0333, 1'b1, 1'b1, 1'b1);

        applyStimulus(1'b0, 1'b0, 16'h1234, 16'h1111);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset busy", 64'(dutBus.busy), 64'd0);
        checkOutput("midReset sum", 64'(dutBus.sum), 64'd0);
        checkOutput("midReset cout", 64'(dutBus.cout), 64'd0);
        checkOutput("midReset ovf", 64'(dutBus.ovf), 64'd0);
        doneSeen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            doneSeen |= dutBus.done;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            doneSeen |= dutBus.done;
        end
        checkOutput("midReset noDone", 64'(doneSeen), 64'd0);
        prevSum = 16'h0000;
        runVector("afterReset", 1'b0, 1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0);

        directedDone = 1'b1;
        wait (sweepDone == 3'b111);
        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

    // Random add/sub sweeps on other shapes, checked against integer arithmetic.
    for (genvar g = 0; g < 3; g++) begin : gSweep
        localparam int W = (g == 0) ? 8 : (g == 1) ? 32 : 12;
        localparam int D = (g == 0) ? 8 : (g == 1) ? 1 : 3;
        localparam int N = W / D;

        digit_serial_adder_if #(.WIDTH(W)) sBus ();

        digit_serial_adder #(.WIDTH(W), .DIGIT(D)) sDut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (sBus)
        );

        initial begin
            longint mask;
            longint half;
            longint x, y, sx, sy, r, eSum;
            logic   s, c, eCout, eOvf;
            int     lat;
            mask = (longint'(1) << W) - 1;
            half = longint'(1) << (W - 1);
            sBus.start = 1'b0;
            sBus.sub   = 1'b0;
            sBus.cin   = 1'b0;
            sBus.a     = '0;
            sBus.b     = '0;
            wait (directedDone);
            @(posedge clk);
            #1;
            for (int i = 0; i < 1000; i++) begin
                x = longint'($urandom) & mask;
                y = longint'($urandom) & mask;
                s = 1'($urandom_range(0, 1));
                c = 1'($urandom_range(0, 1));
                sx = (x >= half) ? x - (mask + 1) : x;
                sy = (y >= half) ? y - (mask + 1) : y;
                if (s) begin
                    eSum  = (x - y - longint'(c)) & mask;
                    eCout = (x >= y + longint'(c));
                    r     = sx - sy - longint'(c);
                end else begin
                    eSum  = (x + y + longint'(c)) & mask;
                    eCout = ((x + y + longint'(c)) > mask);
                    r     = sx + sy + longint'(c);
                end
                eOvf = (r >= half) || (r < -half);
                sBus.start = 1'b1;
                sBus.sub   = s;
                sBus.cin   = c;
                sBus.a     = W'(x);
                sBus.b     = W'(y);
                @(posedge clk);
                #1;
                sBus.start = 1'b0;
                lat = 0;
                while (!sBus.done && lat < N + 4) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                checkOutput($sformatf("w%0dd%0d latency", W, D), 64'(lat), 64'(N));
                checkOutput($sformatf("w%0dd%0d sum", W, D), 64'(sBus.sum), 64'(eSum));
                checkOutput($sformatf("w%0dd%0d cout", W, D), 64'(sBus.cout), 64'(eCout));
                checkOutput($sformatf("w%0dd%0d ovf", W, D), 64'(sBus.ovf), 64'(eOvf));
            end
            sweepDone[g] = 1'b1;
        end
    end
endmodule
